// File: rtl/wbr_chain_ctrl_if.sv
// wbr_chain_ctrl_if: command/response bundle between instruction decode and wbr_chain_ctrl.
// Latency: none, wires only. WBR_CHAIN_CTRL_PARITY_EN adds cmd_par and rsp_par.
// Backpressure: valid/ready on both the command and the response channel.
interface wbr_chain_ctrl_if #(
  parameter int LEN = 8
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [LEN-1:0] cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [LEN-1:0] rsp_data;
  logic           rsp_err;
`ifdef WBR_CHAIN_CTRL_PARITY_EN
  logic           cmd_par;
  logic           rsp_par;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_par, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_par);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, cmd_par, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_par);
`else
  modport master (output cmd_valid, cmd_op, cmd_data, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_data, rsp_err);
  modport slave  (input  cmd_valid, cmd_op, cmd_data, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_data, rsp_err);
`endif
endinterface

// File: rtl/wbr_chain_ctrl.sv
// wbr_chain_ctrl: sequences capture/shift/update/transfer on one WBR chain; WBR_CHAIN_CTRL_PARITY_EN adds parity.
// Latency to rsp_valid: 1 (NOP/SET_CFG/error), 2 (CAPTURE/UPDATE/TRANSFER), LEN+1 (SHIFT), LEN+3 (CSU).
// Backpressure: one command in flight; cmd_ready stays low until the held response is taken.
module wbr_chain_ctrl #(
  parameter int LEN = 8
) (
  input  logic            clk,
  input  logic            arst,
  wbr_chain_ctrl_if.slave bus,
  output logic            busy,
  output logic            wsi,
  input  logic            wso,
  output logic            shift,
  output logic            capture,
  output logic            transfer,
  output logic            update,
  output logic            mode,
  output logic            safe,
  output logic            io_face
);
  localparam int CW = $clog2(LEN + 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_CAPTURE = 3'd1;
  localparam logic [2:0] OP_SHIFT   = 3'd2;
  localparam logic [2:0] OP_UPDATE  = 3'd3;
  localparam logic [2:0] OP_CSU     = 3'd4;
  localparam logic [2:0] OP_XFER    = 3'd5;
  localparam logic [2:0] OP_SET_CFG = 3'd6;

  typedef enum logic [2:0] {IDLE, CAPT, SHFT, UPD, XFER, RESP} state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic [LEN-1:0] rsp_data_q, rsp_data_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     cfg_q, cfg_d;
  logic           rsp_err_q, rsp_err_d;
  logic           cmd_ready_q, rsp_valid_q;
  logic           accept, par_bad;

`ifdef WBR_CHAIN_CTRL_PARITY_EN
  logic rsp_par_q;
  assign par_bad     = bus.cmd_par != ^{bus.cmd_op, bus.cmd_data};
  assign bus.rsp_par = rsp_par_q;
`else
  assign par_bad = 1'b0;
`endif

  assign accept        = (state_q == IDLE) && cmd_ready_q && bus.cmd_valid;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign {io_face, safe, mode} = cfg_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pat_d      = pat_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cfg_d      = cfg_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = bus.cmd_op;
          pat_d     = bus.cmd_data;
          rsp_err_d = 1'b0;
          state_d   = RESP;
          if (par_bad) begin
            rsp_err_d = 1'b1;
          end else begin
            case (bus.cmd_op)
              OP_NOP:             state_d = RESP;
              OP_CAPTURE, OP_CSU: state_d = CAPT;
              OP_SHIFT: begin
                state_d = SHFT;
                cnt_d   = '0;
              end
              OP_UPDATE:          state_d = UPD;
              OP_XFER:            state_d = XFER;
              OP_SET_CFG:         cfg_d   = bus.cmd_data[2:0];
              default:            rsp_err_d = 1'b1;
            endcase
          end
        end
      end
      CAPT: begin
        if (op_q == OP_CSU) begin
          state_d = SHFT;
          cnt_d   = '0;
        end else begin
          state_d = RESP;
        end
      end
      SHFT: begin
        // Tail bit enters at the MSB so the cycle-k sample ends up in bit k.
        rsp_data_d = (rsp_data_q >> 1) | (LEN'(wso) << (LEN - 1));
        pat_d      = pat_q >> 1;
        if (cnt_q == CW'(LEN - 1)) begin
          state_d = (op_q == OP_CSU) ? UPD : RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      UPD, XFER: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so every pin comes from a flop.
  always_ff @(posedge clk) begin
    if (!arst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      pat_q       <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cfg_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy        <= 1'b0;
      wsi         <= 1'b0;
      shift       <= 1'b0;
      capture     <= 1'b0;
      transfer    <= 1'b0;
      update      <= 1'b0;
`ifdef WBR_CHAIN_CTRL_PARITY_EN
      rsp_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cfg_q       <= cfg_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      busy        <= (state_d != IDLE);
      wsi         <= (state_d == SHFT) && pat_d[0];
      shift       <= (state_d == SHFT);
      capture     <= (state_d == CAPT);
      transfer    <= (state_d == XFER);
      update      <= (state_d == UPD);
`ifdef WBR_CHAIN_CTRL_PARITY_EN
      rsp_par_q   <= ^rsp_data_d;
`endif
    end
  end
endmodule

// File: tb/tb_wbr_chain_ctrl.sv
// Bench for wbr_chain_ctrl: a behavioural chain (shift register + capture pins) hangs off wsi/wso,
// and a per-command model predicts latency, strobe counts, shifted-out data and config.
module tb_wbr_chain_ctrl;
  localparam int LEN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst;
  logic busy, wsi, wso, shift, capture, transfer, update, mode, safe, io_face;

  wbr_chain_ctrl_if #(.LEN(LEN)) bus ();

  wbr_chain_ctrl #(.LEN(LEN)) dut (
    .clk(clk), .arst(arst), .bus(bus.slave), .busy(busy), .wsi(wsi), .wso(wso),
    .shift(shift), .capture(capture), .transfer(transfer), .update(update),
    .mode(mode), .safe(safe), .io_face(io_face)
  );

  // Behavioural chain: bit 0 is the tail cell, wsi enters at the head (MSB side).
  logic [LEN-1:0] chain, pins, preload_val;
  logic           preload_req;
  always @(posedge clk) begin
    if (preload_req)  chain <= preload_val;
    else if (capture) chain <= pins;
    else if (shift)   chain <= {wsi, chain[LEN-1:1]};
  end
  assign wso = chain[0];

  int tests = 0;
  int fails = 0;

  // Observations collected by do_cmd
  int             obs_lat, obs_ns, obs_nc, obs_nu, obs_nx, obs_multi, obs_wsi_bad, obs_rdy_bad, obs_hold_bad;
  logic           obs_timeout, obs_idle_ok, obs_err, obs_rpar;
  logic [LEN-1:0] obs_wsi, obs_rsp;
  logic [2:0]     obs_cfg;
`ifdef WBR_CHAIN_CTRL_PARITY_EN
  logic           cmd_par_flip = 1'b0;
`endif

  // Reference model state and per-command expectations
  logic [LEN-1:0] m_chain, m_rsp;
  logic [2:0]     m_cfg;
  int             e_lat, e_ns, e_nc, e_nu, e_nx;
  logic           e_err;

  function automatic logic gp(input logic [2:0] op, input logic [LEN-1:0] d);
    return ^{op, d};
  endfunction

  task automatic model(input logic [2:0] op, input logic [LEN-1:0] d, input logic bad_par);
    e_ns = 0; e_nc = 0; e_nu = 0; e_nx = 0; e_lat = 1;
    e_err = bad_par || (op == 3'd7);
    if (!e_err) begin
      case (op)
        3'd1: begin e_nc = 1; e_lat = 2; m_chain = pins; end
        3'd2: begin e_ns = LEN; e_lat = LEN + 1; m_rsp = m_chain; m_chain = d; end
        3'd3: begin e_nu = 1; e_lat = 2; end
        3'd4: begin e_nc = 1; e_ns = LEN; e_nu = 1; e_lat = LEN + 3; m_rsp = pins; m_chain = d; end
        3'd5: begin e_nx = 1; e_lat = 2; end
        3'd6: m_cfg = d[2:0];
        default: ;
      endcase
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [LEN-1:0] d, input int hold);
    int n, k, ns;
    obs_ns = 0; obs_nc = 0; obs_nu = 0; obs_nx = 0; obs_multi = 0; obs_wsi_bad = 0;
    obs_rdy_bad = 0; obs_hold_bad = 0; obs_wsi = '0; obs_idle_ok = 1'b0; obs_timeout = 1'b1;
    bus.rsp_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d;
`ifdef WBR_CHAIN_CTRL_PARITY_EN
    bus.cmd_par = gp(op, d) ^ cmd_par_flip;
`endif
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_data = LEN'($urandom); bus.cmd_op = 3'($urandom);
    n = 0; k = 0;
    while (n < 4 * LEN + 20) begin
      @(negedge clk); n++;
      ns = int'(shift) + int'(capture) + int'(update) + int'(transfer);
      if (ns > 1) obs_multi++;
      if (shift) begin if (k < LEN) obs_wsi[k] = wsi; k++; end
      else if (wsi) obs_wsi_bad++;
      obs_ns += int'(shift); obs_nc += int'(capture); obs_nu += int'(update); obs_nx += int'(transfer);
      if (bus.cmd_ready || !busy) obs_rdy_bad++;
      if (bus.rsp_valid) begin obs_timeout = 1'b0; break; end
    end
    obs_lat = n; obs_rsp = bus.rsp_data; obs_err = bus.rsp_err; obs_cfg = {io_face, safe, mode};
`ifdef WBR_CHAIN_CTRL_PARITY_EN
    obs_rpar = bus.rsp_par;
`else
    obs_rpar = 1'b0;
`endif
    if (!obs_timeout) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!bus.rsp_valid || bus.rsp_data !== obs_rsp || bus.rsp_err !== obs_err || bus.cmd_ready)
          obs_hold_bad++;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      obs_idle_ok = bus.cmd_ready && !busy && !bus.rsp_valid;
    end else begin
      bus.rsp_ready = 1'b1;
    end
  endtask

  task automatic preload(input logic [LEN-1:0] v);
    @(negedge clk); preload_req = 1'b1; preload_val = v;
    @(negedge clk); preload_req = 1'b0;
    m_chain = v;
  endtask

  task automatic test_reset();
    logic [11:0] v;
    arst = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    preload_req = 1'b1; preload_val = '0; pins = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); arst = 1'b1; preload_req = 1'b0;
    m_chain = '0; m_rsp = '0; m_cfg = '0;
    @(negedge clk);
    v = {bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_err, shift, capture, update, transfer, wsi, mode, safe, io_face};
    tests++; if (v !== 12'h800) begin fails++; $display("FAIL reset_outputs: got %h want %h", v, 12'h800); end
    tests++; if (bus.rsp_data !== '0) begin fails++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
    repeat (3) @(negedge clk);
    v = {bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_err, shift, capture, update, transfer, wsi, mode, safe, io_face};
    tests++; if (v !== 12'h800) begin fails++; $display("FAIL idle_outputs: got %h want %h", v, 12'h800); end
  endtask

  task automatic test_shift();
    preload(8'h3C);
    model(3'd2, 8'hA5, 1'b0);
    do_cmd(3'd2, 8'hA5, 0);
    tests++; if (obs_ns !== 8) begin fails++; $display("FAIL shift_cycles: got %0d want 8", obs_ns); end
    tests++; if (obs_wsi !== 8'hA5) begin fails++; $display("FAIL shift_wsi: got %h want a5", obs_wsi); end
    tests++; if (obs_rsp !== 8'h3C) begin fails++; $display("FAIL shift_rsp: got %h want 3c", obs_rsp); end
    tests++; if (obs_err !== 1'b0) begin fails++; $display("FAIL shift_err: got %b want 0", obs_err); end
    tests++; if (obs_lat !== LEN + 1) begin fails++; $display("FAIL shift_lat: got %0d want %0d", obs_lat, LEN + 1); end
    tests++; if (obs_wsi_bad !== 0) begin fails++; $display("FAIL shift_wsi_idle: got %0d want 0", obs_wsi_bad); end
  endtask

  task automatic test_csu();
    pins = 8'h69;
    model(3'd4, 8'hFF, 1'b0);
    do_cmd(3'd4, 8'hFF, 0);
    tests++; if (obs_lat !== 11) begin fails++; $display("FAIL csu_lat: got %0d want 11", obs_lat); end
    tests++; if ({obs_nc, obs_ns, obs_nu, obs_nx} !== {32'd1, 32'd8, 32'd1, 32'd0})
      begin fails++; $display("FAIL csu_strobes: got c%0d s%0d u%0d x%0d want c1 s8 u1 x0", obs_nc, obs_ns, obs_nu, obs_nx); end
    tests++; if (obs_multi !== 0) begin fails++; $display("FAIL csu_onehot: got %0d want 0", obs_multi); end
    tests++; if (obs_rsp !== m_rsp) begin fails++; $display("FAIL csu_rsp: got %h want %h", obs_rsp, m_rsp); end
    tests++; if (obs_wsi !== 8'hFF) begin fails++; $display("FAIL csu_wsi: got %h want ff", obs_wsi); end
  endtask

  task automatic test_cfg_transfer();
    model(3'd6, 8'h05, 1'b0);
    do_cmd(3'd6, 8'h05, 0);
    tests++; if (obs_cfg !== 3'b101) begin fails++; $display("FAIL cfg_load: got %b want 101", obs_cfg); end
    tests++; if (obs_ns + obs_nc + obs_nu + obs_nx !== 0) begin fails++; $display("FAIL cfg_strobes: got %0d want 0", obs_ns + obs_nc + obs_nu + obs_nx); end
    tests++; if (obs_lat !== 1) begin fails++; $display("FAIL cfg_lat: got %0d want 1", obs_lat); end
    model(3'd5, 8'h00, 1'b0);
    do_cmd(3'd5, 8'h00, 0);
    tests++; if (obs_nx !== 1) begin fails++; $display("FAIL xfer_cycles: got %0d want 1", obs_nx); end
    tests++; if (obs_cfg !== 3'b101) begin fails++; $display("FAIL xfer_cfg_hold: got %b want 101", obs_cfg); end
  endtask

  task automatic test_err_backpressure();
    model(3'd7, 8'h5A, 1'b0);
    do_cmd(3'd7, 8'h5A, 5);
    tests++; if (obs_err !== 1'b1) begin fails++; $display("FAIL op7_err: got %b want 1", obs_err); end
    tests++; if (obs_hold_bad !== 0) begin fails++; $display("FAIL op7_hold: got %0d unstable cycles want 0", obs_hold_bad); end
    tests++; if (obs_idle_ok !== 1'b1) begin fails++; $display("FAIL op7_idle_after: got %b want 1", obs_idle_ok); end
    tests++; if (obs_rsp !== m_rsp) begin fails++; $display("FAIL op7_rsp_kept: got %h want %h", obs_rsp, m_rsp); end
    tests++; if (obs_cfg !== m_cfg) begin fails++; $display("FAIL op7_cfg_kept: got %b want %b", obs_cfg, m_cfg); end
    tests++; if (obs_ns + obs_nc + obs_nu + obs_nx !== 0) begin fails++; $display("FAIL op7_strobes: got %0d want 0", obs_ns + obs_nc + obs_nu + obs_nx); end
  endtask

  task automatic test_reset_midshift();
    int n, k, vbad;
    logic found;
    logic [11:0] v;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
    bus.rsp_ready = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_data = 8'hC3;
`ifdef WBR_CHAIN_CTRL_PARITY_EN
    bus.cmd_par = gp(3'd2, 8'hC3);
`endif
    @(posedge clk); #1; bus.cmd_valid = 1'b0;
    n = 0; k = 0; found = 1'b0;
    while (n < 40 && !found) begin
      @(negedge clk); n++;
      if (shift) begin if (k == 4) found = 1'b1; else k++; end
    end
    tests++; if (!found) begin fails++; $display("FAIL midshift_reach: got shift index %0d want 4", k); end
    arst = 1'b0;
    @(negedge clk);
    v = {bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_err, shift, capture, update, transfer, wsi, mode, safe, io_face};
    tests++; if (v !== 12'h800) begin fails++; $display("FAIL midshift_outputs: got %h want %h", v, 12'h800); end
    tests++; if (bus.rsp_data !== '0) begin fails++; $display("FAIL midshift_rsp_data: got %h want 0", bus.rsp_data); end
    arst = 1'b1;
    vbad = 0;
    repeat (4) begin @(negedge clk); if (bus.rsp_valid || busy) vbad++; end
    tests++; if (vbad !== 0) begin fails++; $display("FAIL midshift_no_rsp: got %0d busy/valid cycles want 0", vbad); end
    m_rsp = '0; m_cfg = '0;
    preload(8'h96);
  endtask

`ifdef WBR_CHAIN_CTRL_PARITY_EN
  task automatic test_parity();
    logic [2:0] cfg_before;
    cfg_before = m_cfg;
    cmd_par_flip = 1'b1;
    model(3'd2, 8'h3E, 1'b1);
    do_cmd(3'd2, 8'h3E, 0);
    cmd_par_flip = 1'b0;
    tests++; if (obs_err !== 1'b1) begin fails++; $display("FAIL par_err: got %b want 1", obs_err); end
    tests++; if (obs_ns !== 0) begin fails++; $display("FAIL par_noshift: got %0d want 0", obs_ns); end
    tests++; if (obs_lat !== 1) begin fails++; $display("FAIL par_lat: got %0d want 1", obs_lat); end
    tests++; if (obs_cfg !== cfg_before) begin fails++; $display("FAIL par_cfg: got %b want %b", obs_cfg, cfg_before); end
  endtask
`endif

  task automatic test_random();
    logic [2:0]     op;
    logic [LEN-1:0] d;
    logic           pb;
    int             hold;
    for (int it = 0; it < 40; it++) begin
      op = 3'($urandom_range(0, 7)); d = LEN'($urandom); pins = LEN'($urandom);
      hold = $urandom_range(0, 2); pb = 1'b0;
`ifdef WBR_CHAIN_CTRL_PARITY_EN
      pb = ($urandom_range(0, 7) == 0);
      cmd_par_flip = pb;
`endif
      model(op, d, pb);
      do_cmd(op, d, hold);
      tests++; if (obs_timeout) begin fails++; $display("FAIL rnd_timeout op%0d: got no rsp want rsp", op); end
      tests++; if (obs_lat !== e_lat) begin fails++; $display("FAIL rnd_lat op%0d: got %0d want %0d", op, obs_lat, e_lat); end
      tests++; if ({obs_nc, obs_ns, obs_nu, obs_nx} !== {e_nc, e_ns, e_nu, e_nx})
        begin fails++; $display("FAIL rnd_strobes op%0d: got c%0d s%0d u%0d x%0d want c%0d s%0d u%0d x%0d", op, obs_nc, obs_ns, obs_nu, obs_nx, e_nc, e_ns, e_nu, e_nx); end
      tests++; if (obs_multi + obs_wsi_bad + obs_rdy_bad + obs_hold_bad !== 0)
        begin fails++; $display("FAIL rnd_protocol op%0d: got multi%0d wsi%0d rdy%0d hold%0d want all 0", op, obs_multi, obs_wsi_bad, obs_rdy_bad, obs_hold_bad); end
      tests++; if (obs_rsp !== m_rsp) begin fails++; $display("FAIL rnd_rsp op%0d: got %h want %h", op, obs_rsp, m_rsp); end
      tests++; if (obs_err !== e_err) begin fails++; $display("FAIL rnd_err op%0d: got %b want %b", op, obs_err, e_err); end
      tests++; if (obs_cfg !== m_cfg) begin fails++; $display("FAIL rnd_cfg op%0d: got %b want %b", op, obs_cfg, m_cfg); end
      tests++; if (obs_idle_ok !== 1'b1) begin fails++; $display("FAIL rnd_idle op%0d: got %b want 1", op, obs_idle_ok); end
      if (e_ns == LEN) begin
        tests++; if (obs_wsi !== d) begin fails++; $display("FAIL rnd_wsi op%0d: got %h want %h", op, obs_wsi, d); end
      end
`ifdef WBR_CHAIN_CTRL_PARITY_EN
      tests++; if (obs_rpar !== ^m_rsp) begin fails++; $display("FAIL rnd_rsp_par op%0d: got %b want %b", op, obs_rpar, ^m_rsp); end
`endif
    end
`ifdef WBR_CHAIN_CTRL_PARITY_EN
    cmd_par_flip = 1'b0;
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_shift();
    test_csu();
    test_cfg_transfer();
    test_err_backpressure();
    test_reset_midshift();
`ifdef WBR_CHAIN_CTRL_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
